// File: rtl/rob_retire_queue.sv
// rob_retire_queue: in-order retire queue that sits after the register renamer.
// Each dispatched instruction takes one slot and records its superseded physical tag.
// Instructions can complete out of order. They retire in program order, at most one
// per cycle. When an instruction retires, its superseded tag goes back to the renamer.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   ena             pipeline enable (gates alloc and retire; completions always land)
//   flush           synchronous discard of every entry
//   alloc_valid     dispatch request
//   alloc_has_dest  dispatched instruction writes a register
//   alloc_wbs       {old_ptag, new_ptag} from the renamer
//   alloc_ready     queue not full
//   alloc_idx       slot handed to the current dispatch (tail)
//   complete_valid  an entry finished execution
//   complete_idx    slot that finished
//   retire_ena_out  one-cycle pulse freeing retire_tag_out in the renamer
//   retire_tag_out  old_ptag of the last retired entry (held between retires)
//   rob_empty       no entries occupied
//   rob_count       number of occupied entries, 0..DEPTH
module rob_retire_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PTAG_W = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                flush,
  input  logic                alloc_valid,
  input  logic                alloc_has_dest,
  input  logic [2*PTAG_W-1:0] alloc_wbs,
  output logic                alloc_ready,
  output logic [IDX_W-1:0]    alloc_idx,
  input  logic                complete_valid,
  input  logic [IDX_W-1:0]    complete_idx,
  output logic                retire_ena_out,
  output logic [PTAG_W-1:0]   retire_tag_out,
  output logic                rob_empty,
  output logic [IDX_W:0]      rob_count
);

  localparam logic [IDX_W:0] FullCount = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  has_dest_q, has_dest_d;
  logic [PTAG_W-1:0] old_ptag_q [DEPTH];
  logic [PTAG_W-1:0] old_ptag_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              retire_ena_q, retire_ena_d;
  logic [PTAG_W-1:0] retire_tag_q, retire_tag_d;

  logic alloc_fire;
  logic retire_fire;

  // new_ptag is deliberately not kept; it remains claimed in the renamer.
  logic unused_new_ptag;
  assign unused_new_ptag = ^alloc_wbs[PTAG_W-1:0];

  // Readiness uses the registered count only, so a same-cycle retire does not open a slot.
  assign alloc_ready    = (count_q != FullCount);
  assign alloc_idx      = tail_q;
  assign rob_empty      = (count_q == '0);
  assign rob_count      = count_q;
  assign retire_ena_out = retire_ena_q;
  assign retire_tag_out = retire_tag_q;

  assign alloc_fire  = alloc_valid & alloc_ready & ena & ~flush;
  assign retire_fire = ena & ~flush & valid_q[head_q] & done_q[head_q];

  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    has_dest_d   = has_dest_q;
    old_ptag_d   = old_ptag_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    retire_ena_d = 1'b0;
    retire_tag_d = retire_tag_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Checked against registered valid, so the slot being allocated now is excluded.
      if (complete_valid && valid_q[complete_idx]) begin
        done_d[complete_idx] = 1'b1;
      end

      if (retire_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        retire_ena_d    = has_dest_q[head_q];
        retire_tag_d    = old_ptag_q[head_q];
      end

      if (alloc_fire) begin
        valid_d[tail_q]    = 1'b1;
        done_d[tail_q]     = 1'b0;
        has_dest_d[tail_q] = alloc_has_dest;
        old_ptag_d[tail_q] = alloc_wbs[2*PTAG_W-1 -: PTAG_W];
        tail_d             = tail_q + 1'b1;
      end

      unique case ({alloc_fire, retire_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      done_q       <= '0;
      has_dest_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        old_ptag_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      retire_ena_q <= 1'b0;
      retire_tag_q <= '0;
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      has_dest_q   <= has_dest_d;
      old_ptag_q   <= old_ptag_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      retire_ena_q <= retire_ena_d;
      retire_tag_q <= retire_tag_d;
    end
  end

endmodule
